// File: rtl/ha_array_pkg.sv
// Shared widths, row offsets and group type for the half-adder-array
// partial-product reduction pipeline.
package ha_array_pkg;

    localparam int NUM_ARRAYS = 4;
    localparam int HA_B_W     = 7;
    localparam int HA_T_W     = 9;
    localparam int SUM_W      = 17;
    localparam int NUM_ROWS   = 2 * NUM_ARRAYS;

    typedef struct packed {
        logic [HA_B_W-1:0] b;
        logic [HA_T_W-1:0] t;
    } ha_group_t;

    function automatic int t_off(input int k);
        return 2 * k;
    endfunction

    function automatic int b_off(input int k);
        return 2 * k + 2;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bitwise full-adder row compressor: three rows in, sum row and
// left-shifted carry row out, both modulo 2^WIDTH.
module csa_3to2 #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    always_comb begin
        sum      = a ^ b ^ c;
        carry[0] = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = (a[i-1] & b[i-1]) | (a[i-1] & c[i-1]) | (b[i-1] & c[i-1]);
        end
    end

endmodule

// File: rtl/ha_array_reduce_pipe.sv
// Reduces four HA-array {b,t} groups to the final product through a
// registered 3:2 carry-save tree and a registered carry-propagate adder.
module ha_array_reduce_pipe
    import ha_array_pkg::*;
#(
    parameter int OUT_W    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        ha_array_0_b,
    input  logic [6:0]        ha_array_1_b,
    input  logic [6:0]        ha_array_2_b,
    input  logic [6:0]        ha_array_3_b,
    input  logic [8:0]        ha_array_0_t,
    input  logic [8:0]        ha_array_1_t,
    input  logic [8:0]        ha_array_2_t,
    input  logic [8:0]        ha_array_3_t,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  product,
    output logic              overflow
);

    localparam logic [SUM_W-1:0] MAX_VAL = SUM_W'((1 << OUT_W) - 1);

    function automatic logic is_over(input logic [SUM_W-1:0] v);
        return v > MAX_VAL;
    endfunction

    function automatic logic [OUT_W-1:0] sat_product(input logic [SUM_W-1:0] v);
        if (SATURATE && is_over(v)) begin
            return '1;
        end
        return v[OUT_W-1:0];
    endfunction

    ha_group_t        grp [NUM_ARRAYS];
    logic [SUM_W-1:0] rows [NUM_ROWS];

    assign grp[0] = '{b: ha_array_0_b, t: ha_array_0_t};
    assign grp[1] = '{b: ha_array_1_b, t: ha_array_1_t};
    assign grp[2] = '{b: ha_array_2_b, t: ha_array_2_t};
    assign grp[3] = '{b: ha_array_3_b, t: ha_array_3_t};

    always_comb begin
        for (int k = 0; k < NUM_ARRAYS; k++) begin
            rows[2*k]   = SUM_W'(grp[k].t) << t_off(k);
            rows[2*k+1] = SUM_W'(grp[k].b) << b_off(k);
        end
    end

    // Tree 8 -> 6 -> 4 -> 3 -> 2; wrap-around is harmless because the true sum fits in SUM_W.
    logic [SUM_W-1:0] a0_s, a0_c, a1_s, a1_c;
    logic [SUM_W-1:0] b0_s, b0_c, b1_s, b1_c;
    logic [SUM_W-1:0] c0_s, c0_c;
    logic [SUM_W-1:0] d0_s, d0_c;

    csa_3to2 #(.WIDTH(SUM_W)) u_csa_a0 (.a(rows[0]), .b(rows[1]), .c(rows[2]), .sum(a0_s), .carry(a0_c));
    csa_3to2 #(.WIDTH(SUM_W)) u_csa_a1 (.a(rows[3]), .b(rows[4]), .c(rows[5]), .sum(a1_s), .carry(a1_c));
    csa_3to2 #(.WIDTH(SUM_W)) u_csa_b0 (.a(a0_s),    .b(a0_c),    .c(a1_s),    .sum(b0_s), .carry(b0_c));
    csa_3to2 #(.WIDTH(SUM_W)) u_csa_b1 (.a(a1_c),    .b(rows[6]), .c(rows[7]), .sum(b1_s), .carry(b1_c));
    csa_3to2 #(.WIDTH(SUM_W)) u_csa_c0 (.a(b0_s),    .b(b0_c),    .c(b1_s),    .sum(c0_s), .carry(c0_c));
    csa_3to2 #(.WIDTH(SUM_W)) u_csa_d0 (.a(c0_s),    .b(c0_c),    .c(b1_c),    .sum(d0_s), .carry(d0_c));

    logic             vld_p1;
    logic [SUM_W-1:0] sum_p1;
    logic [SUM_W-1:0] carry_p1;
    logic             s2_ready;
    logic [SUM_W-1:0] tot;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !vld_p1 || s2_ready;
    assign tot      = sum_p1 + carry_p1;

    // Stage p1: carry-save rows
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
        if (in_valid && in_ready) begin
            sum_p1   <= d0_s;
            carry_p1 <= d0_c;
        end
    end

    // Stage p2: carry-propagate add and output clamp
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            product   <= '0;
            overflow  <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                product  <= sat_product(tot);
                overflow <= is_over(tot);
            end
        end
    end

endmodule

// File: tb/tb_ha_array_reduce_pipe.sv
// Scoreboard bench: saturating and truncating instances share stimulus;
// a monitor checks every delivered product against queued weighted sums.
module tb_ha_array_reduce_pipe;

    typedef struct {
        logic [16:0] s;
        int          cyc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [6:0]  b [4];
    logic [8:0]  t [4];
    logic [6:0]  nb [4];
    logic [8:0]  nt [4];
    logic        in_ready_s, in_ready_t;
    logic        out_valid_s, out_valid_t;
    logic [15:0] product_s, product_t;
    logic        overflow_s, overflow_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_push = 0;
    int          n_pop = 0;
    int          n_flush = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ha_array_reduce_pipe #(.OUT_W(16), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .ha_array_0_b(b[0]), .ha_array_1_b(b[1]), .ha_array_2_b(b[2]), .ha_array_3_b(b[3]),
        .ha_array_0_t(t[0]), .ha_array_1_t(t[1]), .ha_array_2_t(t[2]), .ha_array_3_t(t[3]),
        .out_valid(out_valid_s), .out_ready(out_ready), .product(product_s), .overflow(overflow_s)
    );

    ha_array_reduce_pipe #(.OUT_W(16), .SATURATE(1'b0)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
        .ha_array_0_b(b[0]), .ha_array_1_b(b[1]), .ha_array_2_b(b[2]), .ha_array_3_b(b[3]),
        .ha_array_0_t(t[0]), .ha_array_1_t(t[1]), .ha_array_2_t(t[2]), .ha_array_3_t(t[3]),
        .out_valid(out_valid_t), .out_ready(out_ready), .product(product_t), .overflow(overflow_t)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ref_sum();
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            s += int'(nt[k]) << (2 * k);
            s += int'(nb[k]) << (2 * k + 2);
        end
        return 17'(s);
    endfunction

    task automatic clear_stage();
        for (int k = 0; k < 4; k++) begin
            nb[k] = '0;
            nt[k] = '0;
        end
    endtask

    // One clock: apply staged data and handshake, then record acceptance.
    task automatic step(input bit v, input bit ordy, input logic [16:0] exp_s,
                        input bit lat, output bit acc);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            b[k] = nb[k];
            t[k] = nt[k];
        end
        in_valid  = v;
        out_ready = ordy;
        @(negedge clk);
        acc = in_valid && in_ready_s;
        if (acc) begin
            q.push_back('{s: exp_s, cyc: cyc, lat: lat});
            n_push++;
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, ordy, 17'd0, 1'b0, acc);
    endtask

    task automatic send(input logic [16:0] exp_s, input bit lat);
        bit acc;
        step(1'b1, 1'b1, exp_s, lat, acc);
        check("single_accept", int'(acc), 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid_s && out_ready) begin
                check("valid_agree", int'(out_valid_t), 1);
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    n_pop++;
                    check("product_sat", int'(product_s),
                          (e.s > 17'd65535) ? 65535 : int'(e.s[15:0]));
                    check("overflow_sat", int'(overflow_s), int'(e.s > 17'd65535));
                    check("product_trunc", int'(product_t), int'(e.s[15:0]));
                    check("overflow_trunc", int'(overflow_t), int'(e.s > 17'd65535));
                    if (e.lat) check("latency", cyc - e.cyc, 2);
                end
            end
        end
    end

    initial begin : stimulus
        bit acc;
        int budget;
        int accepted;
        clear_stage();
        for (int k = 0; k < 4; k++) begin
            b[k] = '0;
            t[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid_s), 0);
        check("reset_in_ready", int'(in_ready_s), 1);
        check("reset_product", int'(product_s), 0);
        check("reset_overflow", int'(overflow_s), 0);

        // Single-bit and directed patterns with hand-computed sums
        clear_stage(); nt[0] = 9'h001;             send(17'd1, 1'b1);     idle(3, 1'b1);
        clear_stage(); nt[3] = 9'h100;             send(17'd16384, 1'b1); idle(3, 1'b1);
        clear_stage(); nb[1] = 7'h01;              send(17'd16, 1'b1);    idle(3, 1'b1);
        clear_stage(); nt[2] = 9'h1FF;             send(17'd8176, 1'b1);  idle(3, 1'b1);
        clear_stage(); nb[0] = 7'h7F;              send(17'd508, 1'b1);   idle(3, 1'b1);
        clear_stage(); nb[3] = 7'h40;              send(17'd16384, 1'b1); idle(3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            nb[k] = 7'h7F;
            nt[k] = 9'h1FF;
        end
        send(17'd86615, 1'b1);
        clear_stage(); nt[3] = 9'h100; nb[3] = 7'h40; send(17'd32768, 1'b1);
        idle(3, 1'b1);

        // Back-to-back stream
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 4; k++) begin
                nb[k] = 7'($urandom);
                nt[k] = 9'($urandom);
            end
            step(1'b1, 1'b1, ref_sum(), 1'b1, acc);
            if (!acc) check("stream_accept", 0, 1);
        end
        idle(4, 1'b1);

        // Backpressure: fill both stages, hold, then release
        clear_stage(); nt[0] = 9'h0AB; nb[2] = 7'h11;
        step(1'b1, 1'b0, ref_sum(), 1'b0, acc);
        check("bp_accept_a", int'(acc), 1);
        check("bp_empty_s1_ready", int'(in_ready_s), 1);
        clear_stage(); nt[1] = 9'h155; nb[3] = 7'h7F;
        step(1'b1, 1'b0, ref_sum(), 1'b0, acc);
        check("bp_accept_b", int'(acc), 1);
        clear_stage(); nt[2] = 9'h0FF;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, ref_sum(), 1'b0, acc);
            check("bp_in_ready", int'(in_ready_s), 0);
            check("bp_out_valid", int'(out_valid_s), 1);
            check("bp_hold_product", int'(product_s), int'(q[0].s[15:0]));
        end
        step(1'b0, 1'b1, 17'd0, 1'b0, acc);
        check("bp_release_1", int'(out_valid_s), 1);
        step(1'b0, 1'b1, 17'd0, 1'b0, acc);
        check("bp_release_2", int'(out_valid_s), 1);
        step(1'b0, 1'b1, 17'd0, 1'b0, acc);
        check("bp_release_end", int'(out_valid_s), 0);
        check("bp_queue_empty", q.size(), 0);

        // Random valid/ready toggling
        accepted = 0;
        budget = 0;
        while (accepted < 10000 && budget < 70000) begin
            for (int k = 0; k < 4; k++) begin
                nb[k] = 7'($urandom);
                nt[k] = 9'($urandom);
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ref_sum(), 1'b0, acc);
            if (acc) accepted++;
            budget++;
        end
        check("random_budget", int'(accepted >= 10000), 1);
        budget = 0;
        while (q.size() != 0 && budget < 20) begin
            idle(1, 1'b1);
            budget++;
        end
        check("random_drained", q.size(), 0);

        // Reset with two results in flight
        clear_stage(); nt[0] = 9'h033;
        step(1'b1, 1'b0, ref_sum(), 1'b0, acc);
        clear_stage(); nb[0] = 7'h22;
        step(1'b1, 1'b0, ref_sum(), 1'b0, acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_flush = q.size();
        q.delete();
        @(negedge clk);
        check("rst_flushed_two", n_flush, 2);
        check("rst_out_valid", int'(out_valid_s), 0);
        check("rst_in_ready", int'(in_ready_s), 1);
        check("rst_overflow", int'(overflow_s), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 17'd0, 1'b0, acc);
            check("rst_no_stale", int'(out_valid_s), 0);
        end
        clear_stage(); nt[1] = 9'h001;
        send(17'd4, 1'b1);
        idle(4, 1'b1);
        check("final_queue_empty", q.size(), 0);
        check("push_pop_balance", n_pop, n_push - n_flush);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
